result_dmem_fp16: RTL and testbench

Writer-side counterpart of the FP16 data-memory constant tables. It captures a stream of FP16 results from the FPU into an internal 512x16 RAM at sequential addresses, using a valid/ready handshake. It keeps per-run classification counters (NaN, Inf, zero) and has a registered readback port, so the bench or host can dump captured results against expected tables.

---
 rtl/fp16_pkg.sv | 16 +
 rtl/fp16_classify.sv | 22 ++
 rtl/result_dmem_fp16.sv | 149 ++++++++++++++
 tb/tb_result_dmem_fp16.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 field constants and capture FSM state type
package fp16_pkg;

    localparam int          FP16_EXP_W   = 5;
    localparam int          FP16_MAN_W   = 10;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0] FP16_PZERO   = 16'h0000;
    localparam logic [15:0] FP16_NZERO   = 16'h8000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FINISH  = 2'd2
    } state_e;

endpackage

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational FP16 NaN / Inf / zero classifier
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] data_i,
    output logic        is_nan_o,
    output logic        is_inf_o,
    output logic        is_zero_o
);

    logic [FP16_EXP_W-1:0] exp_f;
    logic [FP16_MAN_W-1:0] man_f;

    assign exp_f = data_i[FP16_MAN_W +: FP16_EXP_W];
    assign man_f = data_i[FP16_MAN_W-1:0];

    // Signed zero has exponent 0, so it can never collide with the NaN/Inf classes.
    assign is_nan_o  = (exp_f == FP16_EXP_MAX) && (man_f != '0);
    assign is_inf_o  = (exp_f == FP16_EXP_MAX) && (man_f == '0);
    assign is_zero_o = (data_i == FP16_PZERO) || (data_i == FP16_NZERO);

endmodule

// File: rtl/result_dmem_fp16.sv
// rtl/result_dmem_fp16.sv - captures an FP16 result stream into RAM with class counters and readback
module result_dmem_fp16
    import fp16_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_ptr,
    output logic [AW:0]   nan_cnt,
    output logic [AW:0]   inf_cnt,
    output logic [AW:0]   zero_cnt,
    output logic          drop_err,
    input  logic [AW-1:0] a,
    output logic [DW-1:0] q
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   nan_q, nan_d;
    logic [AW:0]   inf_q, inf_d;
    logic [AW:0]   zero_q, zero_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] q_q;
    logic [DW-1:0] mem [DEPTH];

    logic hs;
    logic last_word;
    logic c_nan, c_inf, c_zero;

    fp16_classify u_classify (
        .data_i    (in_data),
        .is_nan_o  (c_nan),
        .is_inf_o  (c_inf),
        .is_zero_o (c_zero)
    );

    // A restarting start wins over a handshake in the same cycle.
    assign hs        = in_valid && (state_q == CAPTURE) && !start;
    assign last_word = (wr_ptr_q == len_q - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (len != '0) ? CAPTURE : FINISH;
        end else begin
            case (state_q)
                CAPTURE: if (hs && last_word) state_d = FINISH;
                FINISH:  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == CAPTURE);
        in_ready = (state_q == CAPTURE);
        done     = (state_q == FINISH);
    end

    always_comb begin
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        drop_d   = drop_q;
        if (start) begin
            len_d    = (len > DEPTH_L) ? DEPTH_L : len;
            wr_ptr_d = '0;
            nan_d    = '0;
            inf_d    = '0;
            zero_d   = '0;
            drop_d   = 1'b0;
        end else begin
            if (hs) begin
                wr_ptr_d = wr_ptr_q + ONE;
                nan_d    = nan_q  + {{AW{1'b0}}, c_nan};
                inf_d    = inf_q  + {{AW{1'b0}}, c_inf};
                zero_d   = zero_q + {{AW{1'b0}}, c_zero};
            end
            if (in_valid && !in_ready) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            wr_ptr_q <= '0;
            nan_q    <= '0;
            inf_q    <= '0;
            zero_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            drop_q   <= drop_d;
        end
    end

    // RAM has no reset so captured words survive an abandoned run.
    always_ff @(posedge clk) begin
        if (hs) begin
            mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= mem[a];
        end
    end

    assign wr_ptr   = wr_ptr_q;
    assign nan_cnt  = nan_q;
    assign inf_cnt  = inf_q;
    assign zero_cnt = zero_q;
    assign drop_err = drop_q;
    assign q        = q_q;

endmodule

// File: tb/tb_result_dmem_fp16.sv
// tb/tb_result_dmem_fp16.sv - scoreboard bench for result_dmem_fp16
module tb_result_dmem_fp16;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] a = '0;
    logic          in_ready, busy, done, drop_err;
    logic [AW:0]   wr_ptr, nan_cnt, inf_cnt, zero_cnt;
    logic [DW-1:0] q;

    always #5 clk = ~clk;

    result_dmem_fp16 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .wr_ptr   (wr_ptr),
        .nan_cnt  (nan_cnt),
        .inf_cnt  (inf_cnt),
        .zero_cnt (zero_cnt),
        .drop_err (drop_err),
        .a        (a),
        .q        (q)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int wp;
        int nan;
        int inf;
        int zero;
    } done_t;

    logic [15:0] ref_mem [DEPTH];
    done_t       done_q [$];
    logic [15:0] rd_q [$];
    bit          rd_req = 1'b0;
    bit          rd_vld = 1'b0;

    int m_len = 0, m_acc = 0, m_nan = 0, m_inf = 0, m_zero = 0;
    bit m_active = 1'b0, m_fin = 1'b0, m_drop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = other, 1 = NaN, 2 = Inf, 3 = zero (either sign)
    function automatic int cls(input logic [15:0] w);
        int e;
        int m;
        e = (int'(w) >> 10) & 31;
        m = int'(w) & 1023;
        if (w == 16'h0000 || w == 16'h8000) return 3;
        if (e == 31) return (m != 0) ? 1 : 2;
        return 0;
    endfunction

    task automatic model_clear();
        m_acc = 0; m_nan = 0; m_inf = 0; m_zero = 0; m_drop = 1'b0;
    endtask

    // One clock of stimulus; the model decides what the DUT should do with it.
    task automatic step(input bit st, input int ln, input bit v, input logic [15:0] d, output bit acc);
        logic [31:0] ln_w;
        ln_w = ln;
        @(posedge clk); #1;
        start = st; len = ln_w[AW:0]; in_valid = v; in_data = d;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_active});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        chk("done", {31'd0, done}, {31'd0, m_fin});
        acc = 1'b0;
        m_fin = 1'b0;
        if (st) begin
            m_len = (ln > DEPTH) ? DEPTH : ln;
            model_clear();
            if (m_len != 0) m_active = 1'b1;
            else begin
                m_active = 1'b0;
                m_fin = 1'b1;
                done_q.push_back('{0, 0, 0, 0});
            end
        end else if (m_active && v) begin
            ref_mem[m_acc] = d;
            m_acc++;
            case (cls(d))
                1: m_nan++;
                2: m_inf++;
                3: m_zero++;
                default: ;
            endcase
            acc = 1'b1;
            if (m_acc == m_len) begin
                m_active = 1'b0;
                m_fin = 1'b1;
                done_q.push_back('{m_acc, m_nan, m_inf, m_zero});
            end
        end else if (v) begin
            m_drop = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 16'h0, acc);
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a = i[AW-1:0];
            rd_req = 1'b1;
            rd_q.push_back(ref_mem[i]);
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_wr_ptr"}, {22'd0, wr_ptr}, m_acc);
        chk({tag, "_nan"}, {22'd0, nan_cnt}, m_nan);
        chk({tag, "_inf"}, {22'd0, inf_cnt}, m_inf);
        chk({tag, "_zero"}, {22'd0, zero_cnt}, m_zero);
        chk({tag, "_drop"}, {31'd0, drop_err}, {31'd0, m_drop});
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL readback_underflow: got q=%h expected no read", q);
            end else begin
                chk("readback", {16'd0, q}, {16'd0, rd_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        done_t e;
        if (rst_n && done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
            end else begin
                e = done_q.pop_front();
                chk("done_wr_ptr", {22'd0, wr_ptr}, e.wp);
                chk("done_nan", {22'd0, nan_cnt}, e.nan);
                chk("done_inf", {22'd0, inf_cnt}, e.inf);
                chk("done_zero", {22'd0, zero_cnt}, e.zero);
            end
        end
    end

    logic [15:0] t1_words [20] = '{16'h4601, 16'h38B4, 16'h3C9D, 16'h3B9C, 16'h8000,
                                   16'h3E00, 16'h0000, 16'h4248, 16'h0001, 16'hBC00,
                                   16'h8000, 16'h3555, 16'h47D0, 16'h0000, 16'hC200,
                                   16'h03FF, 16'h2E66, 16'h4400, 16'hB800, 16'h3A00};
    logic [15:0] t2_words [7]  = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01,
                                   16'h0000, 16'h8000, 16'h0001};

    initial begin
        bit acc;
        bit restarted;
        int cyc;

        // reset state
        #23;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_drop", {31'd0, drop_err}, 0);
        chk("rst_wr_ptr", {22'd0, wr_ptr}, 0);
        chk("rst_nan", {22'd0, nan_cnt}, 0);
        chk("rst_inf", {22'd0, inf_cnt}, 0);
        chk("rst_zero", {22'd0, zero_cnt}, 0);
        chk("rst_q", {16'd0, q}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 20 words back to back
        step(1'b1, 20, 1'b0, 16'h0, acc);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 0, 1'b1, t1_words[i], acc);
            chk("t1_accept", {31'd0, acc}, 1);
        end
        idle(2);
        chk_state("t1");
        chk("t1_zero_const", {22'd0, zero_cnt}, 4);
        chk("t1_nan_const", {22'd0, nan_cnt}, 0);
        readback(20);

        // special-value classification
        step(1'b1, 7, 1'b0, 16'h0, acc);
        for (int i = 0; i < 7; i++) step(1'b0, 0, 1'b1, t2_words[i], acc);
        idle(2);
        chk_state("t2");
        chk("t2_inf_const", {22'd0, inf_cnt}, 2);
        chk("t2_nan_const", {22'd0, nan_cnt}, 2);
        chk("t2_zero_const", {22'd0, zero_cnt}, 2);
        chk("t2_wr_ptr_const", {22'd0, wr_ptr}, 7);
        readback(7);

        // zero-length run
        step(1'b1, 0, 1'b0, 16'h0, acc);
        idle(3);
        chk_state("t3");

        // oversize run saturates at DEPTH
        step(1'b1, 600, 1'b0, 16'h0, acc);
        for (int i = 0; i < 600; i++) step(1'b0, 0, 1'b1, 16'($urandom), acc);
        idle(2);
        chk_state("t4");
        chk("t4_wr_ptr_const", {22'd0, wr_ptr}, 512);
        chk("t4_drop_const", {31'd0, drop_err}, 1);
        readback(DEPTH);

        // gapped input with a restart after five accepted words
        step(1'b1, 10, 1'b0, 16'h0, acc);
        restarted = 1'b0;
        cyc = 0;
        while (cyc < 400 && !(restarted && m_acc == 10)) begin
            if (!restarted && m_acc == 5) begin
                step(1'b1, 10, 1'b1, 16'($urandom), acc);
                restarted = 1'b1;
            end else begin
                step(1'b0, 0, 1'($urandom_range(0, 1)), 16'($urandom), acc);
            end
            cyc++;
        end
        chk("t5_timeout", {31'd0, (restarted && m_acc == 10)}, 1);
        idle(2);
        chk_state("t5");
        readback(10);

        // async reset after three words of a run
        step(1'b1, 10, 1'b0, 16'h0, acc);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 16'($urandom), acc);
        @(posedge clk); #3;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_wr_ptr", {22'd0, wr_ptr}, 0);
        chk("t6_in_ready", {31'd0, in_ready}, 0);
        chk("t6_q", {16'd0, q}, 0);
        m_active = 1'b0; m_fin = 1'b0; model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        chk_state("t6");
        readback(3);

        chk("done_queue_empty", done_q.size(), 0);
        chk("read_queue_empty", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
